intr_ctrl: RTL and testbench

Interrupt controller that sequences the CPU's eight vectored interrupt lines into the control unit. It captures request edges, holds pending and in-service state, and applies per-line masking and fixed priority. Each cycle it presents two one-hot vectors: the winning request (`min_bit_s`) and the active service level (`min_bit_a`). It updates its state from the control unit's call and return strobes, which lets interrupts nest under a depth limit.

---
 rtl/intr_pkg.sv | 13 +
 rtl/intr_prio_enc.sv | 16 +
 rtl/intr_ctrl.sv | 133 +++++++++++++
 tb/tb_intr_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// intr_pkg: shared definitions for the interrupt controller.
//   NUM_IRQ   - number of vectored interrupt lines
//   irq_vec_t - one bit per line; used for one-hot and bit-mask vectors
//   MASK_RST  - enable-register value after reset (all lines enabled)
package intr_pkg;

  localparam int NUM_IRQ = 8;

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  localparam irq_vec_t MASK_RST = 8'hFF;

endpackage : intr_pkg

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: isolates the lowest set bit of a vector. Bit 0 has the
// highest priority, so the result is the one-hot highest-priority line.
// The result is 0 when the input is 0.
//   x_i - input vector
//   y_o - one-hot lowest set bit of x_i
module intr_prio_enc
  import intr_pkg::*;
(
  input  logic [NUM_IRQ-1:0] x_i,
  output logic [NUM_IRQ-1:0] y_o
);

  // Two's complement trick: x & -x keeps only the lowest set bit.
  assign y_o = x_i & (~x_i + irq_vec_t'(1));

endmodule : intr_prio_enc

// File: rtl/intr_ctrl.sv
// intr_ctrl: eight-line vectored interrupt controller with edge capture,
// pending/in-service tracking, per-line masking, fixed priority (bit 0
// highest) and bounded nesting.
//   clk, reset     - clock; synchronous active-high reset
//   irq            - request lines; a rising edge raises a request
//   s_intr         - strobe qualifying s_call_intr / s_return_intr
//   s_call_intr    - one-hot interrupt being taken
//   s_return_intr  - one-hot interrupt being retired
//   we_mask        - load mask_in into the enable register
//   mask_in        - per-line enable (1 = enabled)
//   clr_ovr        - clear all overrun flags
//   min_bit_s      - one-hot request allowed to preempt, or 0
//   min_bit_a      - one-hot highest-priority in-service interrupt, or 0
//   pending        - raw pending register
//   ovr            - sticky overrun flags
//   depth          - current nesting depth
// Build option: define INTR_SYNC_EN to pass irq through a two-flop
// synchronizer before edge detection (adds two cycles of latency).
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int MAX_NEST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               s_intr,
  input  logic [NUM_IRQ-1:0] s_call_intr,
  input  logic [NUM_IRQ-1:0] s_return_intr,
  input  logic               we_mask,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               clr_ovr,
  output logic [NUM_IRQ-1:0] min_bit_s,
  output logic [NUM_IRQ-1:0] min_bit_a,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] ovr,
  output logic [3:0]         depth
);

  localparam logic [3:0] MAX_D = 4'(MAX_NEST);

  irq_vec_t irq_q, pending_q, pending_d, is_q, is_d, ovr_q, ovr_d;
  irq_vec_t mask_q, mask_d;
  logic [3:0] depth_q, depth_d;
  irq_vec_t irq_s, edge_v, call_v, ret_v, cand, cand_low, is_low;
  logic call_any, ret_any, ret_hit;

`ifdef INTR_SYNC_EN
  irq_vec_t sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  assign edge_v   = irq_s & ~irq_q;
  assign call_v   = s_intr ? s_call_intr   : '0;
  assign ret_v    = s_intr ? s_return_intr : '0;
  assign call_any = |call_v;
  assign ret_any  = |ret_v;
  assign ret_hit  = |(is_q & ret_v);

  always_comb begin
    // New edges win over a call on the same line, and a line being taken
    // in the same cycle as its new edge is not counted as an overrun.
    pending_d = (pending_q & ~call_v) | edge_v;
    ovr_d     = (clr_ovr ? '0 : ovr_q) | (edge_v & pending_q & ~call_v);
    // Return is applied before call so a line retired and re-taken stays set.
    is_d      = (is_q & ~ret_v) | call_v;
    mask_d    = we_mask ? mask_in : mask_q;
    depth_d   = depth_q;
    if (call_any && ret_any) begin
      depth_d = depth_q;
    end else if (call_any) begin
      if (depth_q < MAX_D) depth_d = depth_q + 4'd1;
    end else if (ret_hit) begin
      if (depth_q != 4'd0) depth_d = depth_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q     <= '0;
      pending_q <= '0;
      is_q      <= '0;
      ovr_q     <= '0;
      mask_q    <= MASK_RST;
      depth_q   <= '0;
    end else begin
      irq_q     <= irq_s;
      pending_q <= pending_d;
      is_q      <= is_d;
      ovr_q     <= ovr_d;
      mask_q    <= mask_d;
      depth_q   <= depth_d;
    end
  end

  assign cand = pending_q & mask_q;

  intr_prio_enc u_enc_cand (
    .x_i (cand),
    .y_o (cand_low)
  );

  intr_prio_enc u_enc_is (
    .x_i (is_q),
    .y_o (is_low)
  );

  // Both outputs depend only on registered state; no strobe feeds through.
  always_comb begin
    min_bit_s = '0;
    if ((depth_q < MAX_D) && ((is_q == '0) || (cand_low < is_low)))
      min_bit_s = cand_low;
  end

  assign min_bit_a = is_low;
  assign pending   = pending_q;
  assign ovr       = ovr_q;
  assign depth     = depth_q;

endmodule : intr_ctrl

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed self-checking bench for intr_ctrl built with
// MAX_NEST = 2 so the nesting limit is reachable.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq, s_call_intr, s_return_intr, mask_in;
  logic       s_intr, we_mask, clr_ovr;
  logic [7:0] min_bit_s, min_bit_a, pending, ovr;
  logic [3:0] depth;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.MAX_NEST(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq           (irq),
    .s_intr        (s_intr),
    .s_call_intr   (s_call_intr),
    .s_return_intr (s_return_intr),
    .we_mask       (we_mask),
    .mask_in       (mask_in),
    .clr_ovr       (clr_ovr),
    .min_bit_s     (min_bit_s),
    .min_bit_a     (min_bit_a),
    .pending       (pending),
    .ovr           (ovr),
    .depth         (depth)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic call(input logic [7:0] v);
    s_intr = 1'b1; s_call_intr = v;
    tick();
    s_intr = 1'b0; s_call_intr = '0;
  endtask

  task automatic ret(input logic [7:0] v);
    s_intr = 1'b1; s_return_intr = v;
    tick();
    s_intr = 1'b0; s_return_intr = '0;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq = v;
    tick();
    irq = '0;
  endtask

  initial begin
    reset = 1'b1; irq = '0; s_intr = 1'b0; s_call_intr = '0;
    s_return_intr = '0; we_mask = 1'b0; mask_in = '0; clr_ovr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pending", pending, 8'h00);
    chk("rst_min_s", min_bit_s, 8'h00);
    chk("rst_min_a", min_bit_a, 8'h00);
    chk("rst_ovr", ovr, 8'h00);
    chk("rst_depth", {4'h0, depth}, 8'h00);

    // Single request and call
    pulse(8'h08);
    chk("irq3_pending", pending, 8'h08);
    chk("irq3_min_s", min_bit_s, 8'h08);
    call(8'h08);
    chk("call3_min_a", min_bit_a, 8'h08);
    chk("call3_min_s", min_bit_s, 8'h00);
    chk("call3_depth", {4'h0, depth}, 8'h01);
    chk("call3_pending", pending, 8'h00);

    // Lower priority blocked, higher priority preempts
    pulse(8'h20);
    chk("irq5_pending", pending, 8'h20);
    chk("irq5_min_s", min_bit_s, 8'h00);
    pulse(8'h02);
    chk("irq1_min_s", min_bit_s, 8'h02);
    call(8'h02);
    chk("call1_depth", {4'h0, depth}, 8'h02);
    chk("call1_min_a", min_bit_a, 8'h02);
    chk("call1_min_s", min_bit_s, 8'h00);
    ret(8'h02);
    chk("ret1_depth", {4'h0, depth}, 8'h01);
    chk("ret1_min_a", min_bit_a, 8'h08);
    chk("ret1_min_s", min_bit_s, 8'h00);
    ret(8'h08);
    chk("ret3_depth", {4'h0, depth}, 8'h00);
    chk("ret3_min_a", min_bit_a, 8'h00);
    chk("ret3_min_s", min_bit_s, 8'h20);

    // Masking keeps the request latched
    we_mask = 1'b1; mask_in = 8'hFE;
    tick();
    we_mask = 1'b0;
    pulse(8'h01);
    chk("mask_pending", pending, 8'h21);
    chk("mask_min_s", min_bit_s, 8'h20);
    we_mask = 1'b1; mask_in = 8'hFF;
    tick();
    we_mask = 1'b0;
    chk("unmask_min_s", min_bit_s, 8'h01);
    call(8'h01);
    chk("call0_min_s", min_bit_s, 8'h00);
    ret(8'h01);
    call(8'h20);
    ret(8'h20);
    chk("drain_pending", pending, 8'h00);
    chk("drain_depth", {4'h0, depth}, 8'h00);

    // Overrun
    pulse(8'h10);
    tick();
    pulse(8'h10);
    chk("ovr_set", ovr, 8'h10);
    chk("ovr_pending", pending, 8'h10);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr", ovr, 8'h00);
    chk("ovr_clr_pending", pending, 8'h10);
    clr_ovr = 1'b1; irq = 8'h10;
    tick();
    clr_ovr = 1'b0; irq = '0;
    chk("ovr_set_wins", ovr, 8'h10);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr2", ovr, 8'h00);
    // Call and new edge on same line: pending stays, no overrun
    irq = 8'h10; s_intr = 1'b1; s_call_intr = 8'h10;
    tick();
    irq = '0; s_intr = 1'b0; s_call_intr = '0;
    chk("calledge_pending", pending, 8'h10);
    chk("calledge_ovr", ovr, 8'h00);
    chk("calledge_min_a", min_bit_a, 8'h10);
    ret(8'h10);
    call(8'h10);
    ret(8'h10);
    chk("drain2_pending", pending, 8'h00);
    chk("drain2_depth", {4'h0, depth}, 8'h00);

    // Nesting limit
    pulse(8'h40);
    call(8'h40);
    pulse(8'h04);
    chk("nest_min_s", min_bit_s, 8'h04);
    call(8'h04);
    chk("nest_depth", {4'h0, depth}, 8'h02);
    pulse(8'h01);
    chk("limit_min_s", min_bit_s, 8'h00);
    chk("limit_pending", pending, 8'h01);
    ret(8'h04);
    chk("limit_ret_depth", {4'h0, depth}, 8'h01);
    chk("limit_ret_min_a", min_bit_a, 8'h40);
    chk("limit_ret_min_s", min_bit_s, 8'h01);

    // Reset mid-nest, with a restrictive mask loaded beforehand
    we_mask = 1'b1; mask_in = 8'h00;
    tick();
    we_mask = 1'b0;
    chk("mask0_min_s", min_bit_s, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_min_s", min_bit_s, 8'h00);
    chk("mid_rst_min_a", min_bit_a, 8'h00);
    chk("mid_rst_pending", pending, 8'h00);
    chk("mid_rst_ovr", ovr, 8'h00);
    chk("mid_rst_depth", {4'h0, depth}, 8'h00);
    pulse(8'h01);
    chk("rst_mask_ff", min_bit_s, 8'h01);

    // Return with nothing in service
    ret(8'h80);
    chk("stray_ret_depth", {4'h0, depth}, 8'h00);
    chk("stray_ret_min_a", min_bit_a, 8'h00);
    chk("stray_ret_pending", pending, 8'h01);
    chk("stray_ret_min_s", min_bit_s, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_intr_ctrl
